// File: rtl/word_digit_decoder.sv
// word_digit_decoder: rewrites spelled-out digit words ("one".."nine") in an
// ASCII byte stream into the digits '1'..'9'. One byte in, one byte out, with
// one cycle of latency. It also counts converted words and accepted newlines.
module word_digit_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_valid,
  input  logic [7:0]       char_in,
  input  logic             words_en,
  output logic             output_valid,
  output logic [7:0]       char_out,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] line_count
);

  localparam logic [7:0] LineFeed = 8'h0A;

  // Previous four accepted raw bytes, newest in the low byte.
  logic [31:0]      r_hist;
  logic             r_valid;
  logic [7:0]       r_char;
  logic [CNT_W-1:0] r_words;
  logic [CNT_W-1:0] r_lines;

  logic [39:0]      w_win;
  logic             w_match;
  logic [7:0]       w_digit;
  logic             w_is_lf;

  assign w_win   = {r_hist, char_in};
  assign w_is_lf = (char_in == LineFeed);

  // Suffix match of the 5-byte window; no word is a suffix of another, so at
  // most one branch can hit.
  always_comb begin
    w_match = 1'b0;
    w_digit = 8'h00;
    if (w_win[23:0] == 24'h6F6E65) begin          // "one"
      w_match = 1'b1;
      w_digit = 8'h31;
    end else if (w_win[23:0] == 24'h74776F) begin // "two"
      w_match = 1'b1;
      w_digit = 8'h32;
    end else if (w_win[39:0] == 40'h7468726565) begin // "three"
      w_match = 1'b1;
      w_digit = 8'h33;
    end else if (w_win[31:0] == 32'h666F7572) begin   // "four"
      w_match = 1'b1;
      w_digit = 8'h34;
    end else if (w_win[31:0] == 32'h66697665) begin   // "five"
      w_match = 1'b1;
      w_digit = 8'h35;
    end else if (w_win[23:0] == 24'h736978) begin     // "six"
      w_match = 1'b1;
      w_digit = 8'h36;
    end else if (w_win[39:0] == 40'h736576656E) begin // "seven"
      w_match = 1'b1;
      w_digit = 8'h37;
    end else if (w_win[39:0] == 40'h6569676874) begin // "eight"
      w_match = 1'b1;
      w_digit = 8'h38;
    end else if (w_win[31:0] == 32'h6E696E65) begin   // "nine"
      w_match = 1'b1;
      w_digit = 8'h39;
    end
  end

  // History keeps raw input bytes (not outputs) so overlapping words such as
  // "eightwo" both decode; a newline clears it so words never span lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 32'h0;
    end else if (input_valid) begin
      if (w_is_lf) begin
        r_hist <= 32'h0;
      end else begin
        r_hist <= {r_hist[23:0], char_in};
      end
    end
  end

  // Output register: valid pulses for one cycle per accepted byte, data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_char  <= 8'h00;
    end else begin
      r_valid <= input_valid;
      if (input_valid) begin
        r_char <= (words_en && w_match) ? w_digit : char_in;
      end
    end
  end

  // Statistics: word count saturates, line count wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words <= '0;
      r_lines <= '0;
    end else if (input_valid) begin
      if (words_en && w_match && (r_words != {CNT_W{1'b1}})) begin
        r_words <= r_words + 1'b1;
      end
      if (w_is_lf) begin
        r_lines <= r_lines + 1'b1;
      end
    end
  end

  assign output_valid = r_valid;
  assign char_out     = r_char;
  assign word_count   = r_words;
  assign line_count   = r_lines;

endmodule

// File: tb/tb_word_digit_decoder.sv
// Directed bench for word_digit_decoder with hand-computed expected streams.
// A narrow counter width lets saturation and wrap be reached quickly.
module tb_word_digit_decoder;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_valid;
  logic [7:0]      char_in;
  logic            words_en;
  logic            output_valid;
  logic [7:0]      char_out;
  logic [CntW-1:0] word_count;
  logic [CntW-1:0] line_count;

  int n_tests = 0;
  int n_fail  = 0;

  word_digit_decoder #(
    .CNT_W(CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .char_in      (char_in),
    .words_en     (words_en),
    .output_valid (output_valid),
    .char_out     (char_out),
    .word_count   (word_count),
    .line_count   (line_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives a string back-to-back and checks each output one cycle later,
  // then one idle cycle where valid must drop and data must hold.
  task automatic send(input string name, input string s, input string exp, input logic en,
                      output string got);
    got = "";
    for (int i = 0; i < s.len(); i++) begin
      input_valid = 1'b1;
      char_in     = s[i];
      words_en    = en;
      @(posedge clk);
      #1;
      check($sformatf("%s vld[%0d]", name, i), {31'd0, output_valid}, 32'd1);
      check($sformatf("%s chr[%0d]", name, i), {24'd0, char_out}, {24'd0, exp[i]});
      got = $sformatf("%s%c", got, char_out);
    end
    input_valid = 1'b0;
    char_in     = 8'h55;
    @(posedge clk);
    #1;
    check($sformatf("%s idle vld", name), {31'd0, output_valid}, 32'd0);
    check($sformatf("%s idle hold", name), {24'd0, char_out}, {24'd0, exp[exp.len()-1]});
  endtask

  task automatic check_counts(input string name, input int wc, input int lc);
    check($sformatf("%s word_count", name), {28'd0, word_count}, wc);
    check($sformatf("%s line_count", name), {28'd0, line_count}, lc);
  endtask

  // Calibration value of one line: first digit * 10 + last digit.
  function automatic int cal(input string s);
    int first = -1;
    int last  = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] >= 8'h30 && s[i] <= 8'h39) begin
        if (first < 0) first = int'(s[i]) - 48;
        last = int'(s[i]) - 48;
      end
    end
    return (first < 0) ? 0 : first * 10 + last;
  endfunction

  initial begin
    string g;
    int    total;
    rst         = 1'b1;
    input_valid = 1'b0;
    char_in     = 8'h00;
    words_en    = 1'b1;
    total       = 0;
    #1;
    check("rst vld", {31'd0, output_valid}, 32'd0);
    check("rst chr", {24'd0, char_out}, 32'd0);
    check_counts("rst", 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send("t1", "two1nine\n", "tw21nin9\n", 1'b1, g);
    total += cal(g);
    check_counts("t1", 2, 1);

    send("t2", "eightwothree\n", "eigh8w2thre3\n", 1'b1, g);
    total += cal(g);
    check_counts("t2", 5, 2);

    send("t3", "on\ne\n", "on\ne\n", 1'b1, g);
    check_counts("t3", 5, 4);

    send("t4", "One\n", "One\n", 1'b1, g);
    check_counts("t4", 5, 5);

    send("t5a", "one\n", "one\n", 1'b0, g);
    check_counts("t5a", 5, 6);
    send("t5b", "six\n", "si6\n", 1'b1, g);
    check_counts("t5b", 6, 7);

    send("t6", "abcone2threexyz\n", "abcon12thre3xyz\n", 1'b1, g);
    total += cal(g);
    check_counts("t6", 8, 8);
    check("chain result", total, 125);

    // Eight more words push the 4-bit word counter past 15.
    send("sat", "onetwothreefourfivesixseveneight\n",
         "on1tw2thre3fou4fiv5si6seve7eigh8\n", 1'b1, g);
    check_counts("sat", 15, 9);

    send("wrap", "\n\n\n\n\n\n\n", "\n\n\n\n\n\n\n", 1'b1, g);
    check_counts("wrap", 15, 0);

    // Partial word, then reset: history must be discarded.
    send("r1", "fi", "fi", 1'b1, g);
    rst = 1'b1;
    #1;
    check("midrst vld", {31'd0, output_valid}, 32'd0);
    check("midrst chr", {24'd0, char_out}, 32'd0);
    check_counts("midrst", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("r2", "ve\n", "ve\n", 1'b1, g);
    check_counts("r2", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
